pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

- Central stall/flush sequencer for the 5-stage pipeline.
- Detects load-use hazards that forwarding cannot cover and inserts exactly one bubble for each.
- Squashes wrong-path instructions on taken branches and jumps.
- Holds the front of the pipeline while the multi-cycle multiplier/divider is busy, with a watchdog and a saturating stall-cycle counter.
- Sits beside the forwarding unit and drives the enables of the PC, FD and DX latches and the nop-injection muxes of DX and XM.

## Interface
Parameters:
- MD_MAX_CYCLES, 34: multdiv watchdog limit, in cycles spent in MD_WAIT.
- CNT_W, 6: width of the watchdog counter.

Ports:
- clock  in  1  pipeline clock.
- reset_n  in  1  asynchronous, active-low reset.
- IR_FD  in  32  instruction in the FD latch.
- ctrl_dx  in  32  DX control word, same packing as the bypass unit: [31:27] rd, [15] RWE, [13] mem_to_reg.
- md_dx  in  1  the DX instruction is mul or div.
- md_ready  in  1  multdiv result valid; one-cycle pulse.
- branch_taken  in  1  taken branch, jump, jal, jr or bex resolved in X this cycle.
- stall_pc  out  1  hold the PC.
- stall_fd  out  1  hold the FD latch.
- stall_dx  out  1  hold the DX latch.
- bubble_dx  out  1  load a nop into DX at the next edge.
- bubble_xm  out  1  load a nop into XM at the next edge.
- flush_fd  out  1  load a nop into FD at the next edge.
- md_start  out  1  start pulse to the multdiv unit.
- md_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  16  saturating count of stall cycles.

## Operation
FD read-set, decoded from IR_FD[31:27]:
- 00000 (R-type): rs [21:17] and rt [16:12].
- 00101 (addi), 01000 (lw): rs.
- 00111 (sw), 00010 (bne), 00110 (blt): rd [26:22] and rs.
- 00100 (jr): rd.
- 10110 (bex): r30.
- Any other opcode: none.

Load-use hazard:
- Condition: ctrl_dx[13] & ctrl_dx[15] & rd_dx != 0 & rd_dx is in the FD read-set.

States: RUN, LD_BUB, MD_WAIT. Outputs are Mealy, decoded from state and inputs. Every output not listed for a case is 0.

RUN, checked in this priority order:
1. branch_taken: flush_fd=1, bubble_dx=1. Stay in RUN.
2. md_dx: md_start=1, stall_pc=1, stall_fd=1, stall_dx=1, bubble_xm=1. Next state MD_WAIT; watchdog counter cleared to 0.
3. Load-use hazard: stall_pc=1, stall_fd=1, bubble_dx=1. Next state LD_BUB.
4. Otherwise: no outputs asserted.

LD_BUB:
- No stall outputs asserted; the load is now in XM and the bypass select-11 path covers it.
- Next state RUN unconditionally, so a single load never costs more than one stall.

MD_WAIT:
- stall_pc=1, stall_fd=1, stall_dx=1, bubble_xm=1, and the counter increments each cycle.
- md_ready=1: drop stall_dx and bubble_xm this cycle so the result advances. Next state RUN.
- Counter reaches MD_MAX_CYCLES-1 without md_ready: set md_timeout and return to RUN (release the pipeline).
- branch_taken is ignored in this state; the stalled instruction cannot be a branch.

Counters:
- stall_cycles increments on every cycle with stall_pc=1 and saturates at 16'hFFFF.
- md_timeout stays set until reset.

## Timing
- All outputs reset to 0; state resets to RUN; both counters reset to 0. Reset is asynchronous in every state, including mid-MD_WAIT.
- Stall and flush outputs take effect at the next clock edge. Load-use cost is 1 cycle.
- Multdiv cost is N+1 stall cycles, where md_ready arrives N cycles after md_start.
- Back-to-back mul/div: the second md_start is issued in the RUN cycle that immediately follows the first md_ready.
- md_start is high for exactly one cycle per operation.

## Structure
- Shared package: opcode constants (R-type, addi, lw, sw, bne, blt, jr, bex), ctrl-word bit indices (RD_HI/LO, RWE, MEM_TO_REG), state encoding (RUN=2'b00, LD_BUB=2'b01, MD_WAIT=2'b10), and the nop encoding.
- One sub-module: fd_readset_decode, which maps IR_FD to {use_a, reg_a, use_b, reg_b}.
- The FSM and both counters live in the top-level module.

## Test plan
- lw r3 in DX, add r4,r3,r5 in FD, no branch: stall_pc=stall_fd=bubble_dx=1 for exactly 1 cycle. Next cycle in LD_BUB all stall outputs are 0. stall_cycles=1.
- lw r0 in DX with r0 read in FD: no stall.
- lw r3 in DX with a hazard in FD, and branch_taken=1 in the same cycle: flush_fd=1, bubble_dx=1, stall_pc=0, state stays RUN.
- mul in DX, md_ready after 32 cycles: md_start pulses once and stalls hold for 33 cycles. At the md_ready cycle stall_dx=0 and stall_pc=1. The following RUN cycle has stall_pc=0.
- mul in DX, md_ready never asserted: md_timeout=1 after 34 cycles in MD_WAIT, then state RUN with stalls released.
- reset_n=0 at cycle 10 of MD_WAIT: all outputs go to 0 immediately, stall_cycles and md_timeout clear, state is RUN. After reset_n=1, two back-to-back muls each get their own md_start pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard sequencer.
// Opcodes, control-word bit positions, FSM states and the FD read-set bundle.
package pipe_hazard_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam int RD_HI      = 31;
    localparam int RD_LO      = 27;
    localparam int RWE        = 15;
    localparam int MEM_TO_REG = 13;

    localparam logic [4:0]  REG_STATUS = 5'd30;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LD_BUB  = 2'b01,
        MD_WAIT = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic       use_a;
        logic [4:0] reg_a;
        logic       use_b;
        logic [4:0] reg_b;
    } readset_t;

    function automatic logic reads_reg(input readset_t s,
                                       input logic [4:0] r);
        return (s.use_a && (s.reg_a == r)) ||
               (s.use_b && (s.reg_b == r));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fd_readset_decode.sv
// Decodes which architectural registers the FD instruction reads.
// Drives the load-use comparison in the hazard sequencer.
module fd_readset_decode
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output readset_t    o_rs
);

    logic [4:0] w_op;
    logic [4:0] w_rd;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_unused_ir;

    assign w_op        = i_ir[31:27];
    assign w_rd        = i_ir[26:22];
    assign w_rs        = i_ir[21:17];
    assign w_rt        = i_ir[16:12];
    assign w_unused_ir = ^i_ir[11:0];

    // Opcode to source-register map; unknown opcodes read nothing.
    always_comb begin
        o_rs = '0;
        unique case (w_op)
            OP_RTYPE: begin
                o_rs.use_a = 1'b1;
                o_rs.reg_a = w_rs;
                o_rs.use_b = 1'b1;
                o_rs.reg_b = w_rt;
            end
            OP_ADDI, OP_LW: begin
                o_rs.use_a = 1'b1;
                o_rs.reg_a = w_rs;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                o_rs.use_a = 1'b1;
                o_rs.reg_a = w_rd;
                o_rs.use_b = 1'b1;
                o_rs.reg_b = w_rs;
            end
            OP_JR: begin
                o_rs.use_a = 1'b1;
                o_rs.reg_a = w_rd;
            end
            OP_BEX: begin
                o_rs.use_a = 1'b1;
                o_rs.reg_a = REG_STATUS;
            end
            default: begin
                o_rs = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: load-use bubbles, branch squash,
// multdiv hold with watchdog, and a saturating stall-cycle counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MD_MAX_CYCLES = 34,
    parameter int CNT_W         = 6
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] IR_FD,
    input  logic [31:0] ctrl_dx,
    input  logic        md_dx,
    input  logic        md_ready,
    input  logic        branch_taken,
    output logic        stall_pc,
    output logic        stall_fd,
    output logic        stall_dx,
    output logic        bubble_dx,
    output logic        bubble_xm,
    output logic        flush_fd,
    output logic        md_start,
    output logic        md_timeout,
    output logic [15:0] stall_cycles
);

    localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_MAX_CYCLES - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_md_cnt;
    logic             r_md_timeout;
    logic [15:0]      r_stall_cycles;

    readset_t   w_fd_rs;
    logic [4:0] w_rd_dx;
    logic       w_load_use;
    logic       w_cnt_clr;
    logic       w_cnt_inc;
    logic       w_timeout;
    logic       w_unused_ctrl;

    fd_readset_decode u_fd_readset_decode (
        .i_ir (IR_FD),
        .o_rs (w_fd_rs)
    );

    assign w_rd_dx       = ctrl_dx[RD_HI:RD_LO];
    assign w_unused_ctrl = ^{ctrl_dx[26:16], ctrl_dx[14], ctrl_dx[12:0]};

    assign w_load_use = ctrl_dx[MEM_TO_REG] && ctrl_dx[RWE] &&
                        (w_rd_dx != 5'd0) &&
                        reads_reg(w_fd_rs, w_rd_dx);

    assign md_timeout   = r_md_timeout;
    assign stall_cycles = r_stall_cycles;

    // Next state and Mealy outputs; all outputs forced low in reset.
    always_comb begin
        w_state_nxt = r_state;
        stall_pc    = 1'b0;
        stall_fd    = 1'b0;
        stall_dx    = 1'b0;
        bubble_dx   = 1'b0;
        bubble_xm   = 1'b0;
        flush_fd    = 1'b0;
        md_start    = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            RUN: begin
                if (branch_taken) begin
                    flush_fd  = 1'b1;
                    bubble_dx = 1'b1;
                end else if (md_dx) begin
                    md_start    = 1'b1;
                    stall_pc    = 1'b1;
                    stall_fd    = 1'b1;
                    stall_dx    = 1'b1;
                    bubble_xm   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = MD_WAIT;
                end else if (w_load_use) begin
                    stall_pc    = 1'b1;
                    stall_fd    = 1'b1;
                    bubble_dx   = 1'b1;
                    w_state_nxt = LD_BUB;
                end
            end
            LD_BUB: begin
                w_state_nxt = RUN;
            end
            MD_WAIT: begin
                stall_pc  = 1'b1;
                stall_fd  = 1'b1;
                stall_dx  = 1'b1;
                bubble_xm = 1'b1;
                w_cnt_inc = 1'b1;
                if (md_ready) begin
                    stall_dx    = 1'b0;
                    bubble_xm   = 1'b0;
                    w_state_nxt = RUN;
                end else if (r_md_cnt == MD_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        if (!reset_n) begin
            stall_pc  = 1'b0;
            stall_fd  = 1'b0;
            stall_dx  = 1'b0;
            bubble_dx = 1'b0;
            bubble_xm = 1'b0;
            flush_fd  = 1'b0;
            md_start  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_md_cnt     <= '0;
            r_md_timeout <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_md_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_md_cnt <= r_md_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_md_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
        end else if (stall_pc && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, branch squash,
// multdiv hold, watchdog timeout and asynchronous reset.
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] IR_FD;
    logic [31:0] ctrl_dx;
    logic        md_dx;
    logic        md_ready;
    logic        branch_taken;
    logic        stall_pc;
    logic        stall_fd;
    logic        stall_dx;
    logic        bubble_dx;
    logic        bubble_xm;
    logic        flush_fd;
    logic        md_start;
    logic        md_timeout;
    logic [15:0] stall_cycles;

    localparam logic [7:0] O_LU  = 8'hD0;
    localparam logic [7:0] O_BR  = 8'h14;
    localparam logic [7:0] O_MDS = 8'hEA;
    localparam logic [7:0] O_MDW = 8'hE8;
    localparam logic [7:0] O_MDR = 8'hC0;
    localparam logic [7:0] O_TO  = 8'h01;

    int n_total = 0;
    int n_bad   = 0;
    int exp_sc  = 0;

    logic [7:0] w_outs;
    assign w_outs = {stall_pc, stall_fd, stall_dx, bubble_dx,
                     bubble_xm, flush_fd, md_start, md_timeout};

    pipe_hazard_ctrl #(
        .MD_MAX_CYCLES (34),
        .CNT_W         (6)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .IR_FD        (IR_FD),
        .ctrl_dx      (ctrl_dx),
        .md_dx        (md_dx),
        .md_ready     (md_ready),
        .branch_taken (branch_taken),
        .stall_pc     (stall_pc),
        .stall_fd     (stall_fd),
        .stall_dx     (stall_dx),
        .bubble_dx    (bubble_dx),
        .bubble_xm    (bubble_xm),
        .flush_fd     (flush_fd),
        .md_start     (md_start),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] exp);
        @(negedge clock);
        chk(tag, {24'd0, w_outs}, {24'd0, exp});
        if (exp[7] && exp_sc < 65535) exp_sc++;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_sc(input string tag);
        chk(tag, {16'd0, stall_cycles}, exp_sc);
    endtask

    function automatic logic [31:0] mk_r(input logic [4:0] rd,
                                         input logic [4:0] rs,
                                         input logic [4:0] rt);
        return {5'b00000, rd, rs, rt, 12'd0};
    endfunction

    function automatic logic [31:0] mk_op(input logic [4:0] op,
                                          input logic [4:0] rd,
                                          input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    function automatic logic [31:0] mk_ctrl(input logic [4:0] rd,
                                            input logic rwe,
                                            input logic m2r);
        logic [31:0] c;
        c = '0;
        c[31:27] = rd;
        c[15] = rwe;
        c[13] = m2r;
        return c;
    endfunction

    initial begin
        IR_FD = '0;
        ctrl_dx = '0;
        md_dx = 1'b0;
        md_ready = 1'b0;
        branch_taken = 1'b0;
        #12;
        chk("rst_outs", {24'd0, w_outs}, 32'd0);
        chk_sc("rst_sc");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc("idle", 8'h00);

        IR_FD = mk_r(5'd4, 5'd3, 5'd5);
        ctrl_dx = mk_ctrl(5'd3, 1'b1, 1'b1);
        cyc("lu_rs", O_LU);
        cyc("lu_rs_bub", 8'h00);
        chk_sc("sc_lu1");
        ctrl_dx = '0;
        cyc("lu_after", 8'h00);
        ctrl_dx = mk_ctrl(5'd5, 1'b1, 1'b1);
        cyc("lu_rt", O_LU);
        ctrl_dx = '0;
        cyc("lu_rt_bub", 8'h00);

        IR_FD = mk_op(5'b00111, 5'd7, 5'd2);
        ctrl_dx = mk_ctrl(5'd7, 1'b1, 1'b1);
        cyc("lu_sw_rd", O_LU);
        ctrl_dx = '0;
        cyc("lu_sw_bub", 8'h00);
        IR_FD = mk_op(5'b00100, 5'd9, 5'd0);
        ctrl_dx = mk_ctrl(5'd9, 1'b1, 1'b1);
        cyc("lu_jr", O_LU);
        ctrl_dx = '0;
        cyc("lu_jr_bub", 8'h00);
        IR_FD = mk_op(5'b10110, 5'd0, 5'd0);
        ctrl_dx = mk_ctrl(5'd30, 1'b1, 1'b1);
        cyc("lu_bex", O_LU);
        ctrl_dx = '0;
        cyc("lu_bex_bub", 8'h00);

        IR_FD = mk_op(5'b00001, 5'd3, 5'd3);
        ctrl_dx = mk_ctrl(5'd3, 1'b1, 1'b1);
        cyc("no_read_op", 8'h00);
        IR_FD = mk_r(5'd4, 5'd3, 5'd5);
        ctrl_dx = mk_ctrl(5'd3, 1'b1, 1'b0);
        cyc("alu_in_dx", 8'h00);
        IR_FD = mk_r(5'd4, 5'd0, 5'd0);
        ctrl_dx = mk_ctrl(5'd0, 1'b1, 1'b1);
        cyc("lw_r0", 8'h00);
        chk_sc("sc_lu5");

        IR_FD = mk_r(5'd4, 5'd3, 5'd5);
        ctrl_dx = mk_ctrl(5'd3, 1'b1, 1'b1);
        branch_taken = 1'b1;
        cyc("br_over_lu", O_BR);
        branch_taken = 1'b0;
        cyc("br_stay_run", O_LU);
        ctrl_dx = '0;
        cyc("br_lu_bub", 8'h00);
        md_dx = 1'b1;
        branch_taken = 1'b1;
        cyc("br_over_md", O_BR);
        branch_taken = 1'b0;
        IR_FD = '0;

        cyc("md_start", O_MDS);
        for (int i = 1; i < 32; i++) cyc($sformatf("md_w%0d", i), O_MDW);
        md_ready = 1'b1;
        cyc("md_ready", O_MDR);
        md_ready = 1'b0;
        md_dx = 1'b0;
        cyc("md_release", 8'h00);
        chk_sc("sc_md");

        md_dx = 1'b1;
        cyc("to_start", O_MDS);
        for (int i = 1; i <= 34; i++) cyc($sformatf("to_w%0d", i), O_MDW);
        md_dx = 1'b0;
        cyc("to_release", O_TO);
        cyc("to_sticky", O_TO);
        chk_sc("sc_to");

        md_dx = 1'b1;
        cyc("rs_start", O_MDS | O_TO);
        for (int i = 1; i < 10; i++) cyc($sformatf("rs_w%0d", i), O_MDW | O_TO);
        @(negedge clock);
        chk("rs_w10", {24'd0, w_outs}, {24'd0, O_MDW | O_TO});
        #2;
        reset_n = 1'b0;
        #1;
        chk("rs_async_outs", {24'd0, w_outs}, 32'd0);
        exp_sc = 0;
        chk_sc("rs_async_sc");
        md_dx = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        md_dx = 1'b1;
        cyc("b2b_s1", O_MDS);
        cyc("b2b_w1a", O_MDW);
        cyc("b2b_w1b", O_MDW);
        md_ready = 1'b1;
        cyc("b2b_r1", O_MDR);
        md_ready = 1'b0;
        cyc("b2b_s2", O_MDS);
        cyc("b2b_w2a", O_MDW);
        cyc("b2b_w2b", O_MDW);
        md_ready = 1'b1;
        cyc("b2b_r2", O_MDR);
        md_ready = 1'b0;
        md_dx = 1'b0;
        cyc("b2b_done", 8'h00);
        chk_sc("sc_b2b");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
